// File: rtl/md_unit_controller_pkg.sv
// md_unit_controller_pkg: MDU opcode encodings and opcode classification helpers.
package md_unit_controller_pkg;
  localparam logic [2:0] MD_NONE  = 3'd0;
  localparam logic [2:0] MD_MULT  = 3'd1;
  localparam logic [2:0] MD_MULTU = 3'd2;
  localparam logic [2:0] MD_DIV   = 3'd3;
  localparam logic [2:0] MD_DIVU  = 3'd4;
  localparam logic [2:0] MD_MTHI  = 3'd5;
  localparam logic [2:0] MD_MTLO  = 3'd6;

  function automatic logic is_start(input logic [2:0] op);
    return op == MD_MULT || op == MD_MULTU || op == MD_DIV || op == MD_DIVU;
  endfunction

  function automatic logic is_mult(input logic [2:0] op);
    return op == MD_MULT || op == MD_MULTU;
  endfunction
endpackage

// File: rtl/md_unit_controller_arith.sv
// md_arith: combinational multiply/divide producing {hi,lo} and a divide-by-zero flag.
module md_arith
  import md_unit_controller_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] res,
  output logic        div_zero
);
  logic        sgn;
  logic [31:0] x, y, q, r, qf, rf;
  logic [63:0] mx, my, p;
  always_comb begin
    sgn = op == MD_DIV;
    div_zero = (op == MD_DIV || op == MD_DIVU) && b == 32'd0;
    // signed divide runs on magnitudes, signs restored afterwards
    x = sgn && a[31] ? -a : a;
    y = sgn && b[31] ? -b : b;
    q = x / (y == 32'd0 ? 32'd1 : y);
    r = x % (y == 32'd0 ? 32'd1 : y);
    qf = sgn && (a[31] ^ b[31]) ? -q : q;
    rf = sgn && a[31] ? -r : r;
    mx = op == MD_MULT ? {{32{a[31]}}, a} : {32'd0, a};
    my = op == MD_MULT ? {{32{b[31]}}, b} : {32'd0, b};
    p = mx * my;
    res = is_mult(op) ? p : {rf, qf};
  end
endmodule

// File: rtl/md_unit_controller.sv
// md_unit_controller: HI/LO owner sequencing mult/div over a fixed latency with a D-stage stall request.
module md_unit_controller
  import md_unit_controller_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [2:0]  md_op_E,
  input  logic [31:0] rs_E,
  input  logic [31:0] rt_E,
  input  logic        md_use_D,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        stall_md
);
  localparam int MAX_CYCLES = MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_MULT, S_DIV} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [63:0]   res_q, res_d, arith_res;
  logic          zero_q, zero_d, arith_zero, start, last;
  logic [31:0]   hi_q, hi_d, lo_q, lo_d;

  assign start = is_start(md_op_E);
  assign last = cnt_q == CW'(1);

  md_arith u_arith (
    .op       (md_op_E),
    .a        (rs_E),
    .b        (rt_E),
    .res      (arith_res),
    .div_zero (arith_zero)
  );

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state_q <= S_IDLE;
    else state_q <= state_d;

  always_comb begin
    state_d = state_q == S_IDLE ? (start ? (is_mult(md_op_E) ? S_MULT : S_DIV) : S_IDLE)
                                : (last ? S_IDLE : state_q);
  end

  always_comb begin
    cnt_d = cnt_q;
    res_d = res_q;
    zero_d = zero_q;
    hi_d = hi_q;
    lo_d = lo_q;
    if (state_q == S_IDLE) begin
      if (start) begin
        cnt_d = is_mult(md_op_E) ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
        res_d = arith_res;
        zero_d = arith_zero;
      end else if (md_op_E == MD_MTHI) hi_d = rs_E;
      else if (md_op_E == MD_MTLO) lo_d = rs_E;
    end else begin
      cnt_d = cnt_q - CW'(1);
      // a zero divisor still runs the full sequence but never commits
      if (last && !zero_q) {hi_d, lo_d} = res_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      cnt_q <= '0;
      res_q <= '0;
      zero_q <= 1'b0;
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      res_q <= res_d;
      zero_q <= zero_d;
      hi_q <= hi_d;
      lo_q <= lo_d;
    end

  always_comb begin
    busy = state_q != S_IDLE;
    stall_md = md_use_D && (busy || start);
    hi = hi_q;
    lo = lo_q;
  end
endmodule

// File: tb/tb_md_unit_controller.sv
// tb_md_unit_controller: random and directed stimulus against a behavioural MDU model.
module tb_md_unit_controller;
  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [2:0]  md_op_E = 3'd0;
  logic [31:0] rs_E = '0, rt_E = '0;
  logic        md_use_D = 1'b0;
  logic [31:0] hi, lo;
  logic        busy, stall_md;

  int n_cmp = 0, n_bad = 0;
  logic [31:0] m_hi = '0, m_lo = '0;
  logic [63:0] m_res = '0;
  bit          m_dz = 0;
  int          m_left = 0;
  logic        last_stall;
  logic [31:0] last_lo;

  md_unit_controller #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .md_op_E  (md_op_E),
    .rs_E     (rs_E),
    .rt_E     (rt_E),
    .md_use_D (md_use_D),
    .hi       (hi),
    .lo       (lo),
    .busy     (busy),
    .stall_md (stall_md)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ref_res(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    longint unsigned ua, ub;
    logic [63:0] v;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'(a);
    ub = longint'(b);
    v = '0;
    if (op == 3'd1) v = sa * sb;
    else if (op == 3'd2) v = ua * ub;
    else if (op == 3'd3 && b != 0) begin
      q = sa / sb;
      r = sa % sb;
      v = {r[31:0], q[31:0]};
    end else if (op == 3'd4 && b != 0) v = {32'(ua % ub), 32'(ua / ub)};
    return v;
  endfunction

  task automatic step(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic use_d);
    bit st;
    @(negedge clk);
    md_op_E = op;
    rs_E = a;
    rt_E = b;
    md_use_D = use_d;
    st = op >= 3'd1 && op <= 3'd4;
    #1;
    last_stall = stall_md;
    last_lo = lo;
    check("stall_md", {63'd0, stall_md}, {63'd0, use_d && (m_left > 0 || st)});
    if (m_left > 0) begin
      m_left--;
      if (m_left == 0 && !m_dz) {m_hi, m_lo} = m_res;
    end else if (st) begin
      m_left = (op <= 3'd2) ? MC : DC;
      m_dz = op >= 3'd3 && b == 0;
      m_res = ref_res(op, a, b);
    end else if (op == 3'd5) m_hi = a;
    else if (op == 3'd6) m_lo = a;
    @(posedge clk);
    #1;
    check("busy", {63'd0, busy}, {63'd0, m_left > 0});
    check("hi", {32'd0, hi}, {32'd0, m_hi});
    check("lo", {32'd0, lo}, {32'd0, m_lo});
  endtask

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, output int nb);
    step(op, a, b, 1'b0);
    nb = 0;
    for (int i = 0; i < 40 && busy === 1'b1; i++) begin
      nb++;
      step(3'd0, '0, '0, 1'b0);
    end
  endtask

  initial begin
    int nb, sc;
    logic [2:0] op;
    logic [31:0] a, b;
    #2 reset_n = 1'b0;
    #1;
    check("rst busy", {63'd0, busy}, 64'd0);
    check("rst hi", {32'd0, hi}, 64'd0);
    check("rst lo", {32'd0, lo}, 64'd0);
    md_use_D = 1'b1;
    #1 check("rst stall idle", {63'd0, stall_md}, 64'd0);
    md_op_E = 3'd1;
    #1 check("rst stall start", {63'd0, stall_md}, 64'd1);
    md_op_E = 3'd0;
    md_use_D = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;

    run_op(3'd1, 32'hFFFFFFFE, 32'd3, nb);
    check("mult cycles", 64'(nb), 64'(MC));
    check("mult hi", {32'd0, hi}, 64'hFFFFFFFF);
    check("mult lo", {32'd0, lo}, 64'hFFFFFFFA);
    run_op(3'd2, 32'hFFFFFFFE, 32'd3, nb);
    check("multu hi", {32'd0, hi}, 64'h2);
    check("multu lo", {32'd0, lo}, 64'hFFFFFFFA);
    run_op(3'd3, 32'hFFFFFFF9, 32'd2, nb);
    check("div cycles", 64'(nb), 64'(DC));
    check("div lo", {32'd0, lo}, 64'hFFFFFFFD);
    check("div hi", {32'd0, hi}, 64'hFFFFFFFF);
    run_op(3'd4, 32'd7, 32'd2, nb);
    check("divu lo", {32'd0, lo}, 64'd3);
    check("divu hi", {32'd0, hi}, 64'd1);

    step(3'd3, 32'd100, 32'd7, 1'b1);
    sc = last_stall ? 1 : 0;
    for (int i = 0; i < 30 && last_stall === 1'b1; i++) begin
      step(3'd0, '0, '0, 1'b1);
      if (last_stall) sc++;
    end
    check("mflo stall cycles", 64'(sc), 64'(DC + 1));
    check("mflo lo at release", {32'd0, last_lo}, 64'd14);

    step(3'd5, 32'h1234, '0, 1'b0);
    check("mthi", {32'd0, hi}, 64'h1234);
    step(3'd6, 32'h5678, '0, 1'b0);
    check("mtlo", {32'd0, lo}, 64'h5678);
    run_op(3'd3, 32'd99, 32'd0, nb);
    check("div0 cycles", 64'(nb), 64'(DC));
    check("div0 hi", {32'd0, hi}, 64'h1234);
    check("div0 lo", {32'd0, lo}, 64'h5678);

    step(3'd1, 32'h10000, 32'h10000, 1'b0);
    step(3'd6, 32'hAAAA, '0, 1'b0);
    check("mtlo ignored", {32'd0, lo}, 64'h5678);
    step(3'd0, '0, '0, 1'b0);
    @(negedge clk);
    md_op_E = 3'd0;
    reset_n = 1'b0;
    #1;
    check("async busy", {63'd0, busy}, 64'd0);
    check("async hi", {32'd0, hi}, 64'd0);
    check("async lo", {32'd0, lo}, 64'd0);
    m_left = 0;
    m_hi = '0;
    m_lo = '0;
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < MC + 4; i++) step(3'd0, '0, '0, 1'b0);
    check("no late commit hi", {32'd0, hi}, 64'd0);

    for (int i = 0; i < 400; i++) begin
      op = 3'($urandom_range(0, 7));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = '0;
        1: b = 32'hFFFFFFFF;
        2: a = 32'h80000000;
        3: b = 32'($urandom_range(1, 9));
        default: ;
      endcase
      step(op, a, b, 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/md_unit_controller.md
# md_unit_controller

Multi-cycle multiply/divide controller for the pipelined MIPS core. It owns the HI/LO registers and sequences MULT/MULTU/DIV/DIVU over a fixed, parameterised latency. It accepts MTHI/MTLO writes and exports HI/LO for MFHI/MFLO. It also raises a stall request that the hazard-resolution logic ORs into its own stall, so that no MDU-class instruction leaves D while an operation is in flight or starting.

## Interface
- `MULT_CYCLES`, default 5: busy cycles for mult/multu; must be ≥1.
- `DIV_CYCLES`, default 10: busy cycles for div/divu; must be ≥1.
- `clk` in 1: single clock. All state changes on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `md_op_E` in 3: MDU opcode of the instruction currently in E. Encodings: `md_none`=0, `md_mult`=1, `md_multu`=2, `md_div`=3, `md_divu`=4, `md_mthi`=5, `md_mtlo`=6. Values 7 and up are treated as none.
- `rs_E` in 32: forwarded rs operand (dividend, multiplicand, or MT source).
- `rt_E` in 32: forwarded rt operand (divisor or multiplier).
- `md_use_D` in 1: the instruction in D is any MDU instruction (mult/div/mf/mt).
- `hi` out 32: architectural HI.
- `lo` out 32: architectural LO.
- `busy` out 1: an operation is in flight.
- `stall_md` out 1: stall request to the hazard unit.

## Operation
- States:
  - IDLE
  - MULT: counter loaded with `MULT_CYCLES`.
  - DIV: counter loaded with `DIV_CYCLES`.
- IDLE to MULT/DIV:
  - Occurs on an edge where `md_op_E` is mult/multu/div/divu.
  - On that edge the full result is latched into internal `res_hi`/`res_lo`. Operands are not held afterwards.
- In MULT/DIV:
  - The counter decrements each edge.
  - On the edge where the counter is 1: copy `res_hi`/`res_lo` into `hi`/`lo`, then return to IDLE.
- Arithmetic:
  - mult: {hi,lo} = signed 64-bit product.
  - multu: {hi,lo} = unsigned 64-bit product.
  - div: lo = signed quotient truncated toward zero; hi = remainder with the sign of the dividend.
  - divu: unsigned quotient and remainder.
- Divide by zero (rt_E=0) on div or divu:
  - Full DIV sequence runs; busy is asserted for the normal duration.
  - HI/LO are left unchanged at completion.
- mthi/mtlo:
  - In IDLE, `hi` or `lo` takes `rs_E` on the next edge. No busy.
  - Any `md_op_E` other than none while busy is ignored. The hazard stall prevents this case; it is not an error.
- `busy` = (state ≠ IDLE).
- `stall_md` = `md_use_D` & (`busy` | `md_op_E` ∈ {mult, multu, div, divu}).
  - The start term covers the cycle the operation sits in E before `busy` rises.
  - `stall_md` is combinational; no register.

## Timing
- Reset (asynchronous, immediate):
  - `hi`=0, `lo`=0, `busy`=0, state IDLE, counter 0.
  - `stall_md` then follows its equation: 0 unless the start term is active.
- Reset mid-operation abandons the operation. HI/LO read 0 afterwards and no late commit occurs.
- A start sampled at edge t gives `busy`=1 for cycles t+1 … t+N (N = MULT_CYCLES or DIV_CYCLES). HI/LO update at edge t+N, and `busy`=0 from t+N.
- MFHI/MFLO in D with `md_use_D`=1 behind a start: `stall_md` is high for N+1 cycles (the start cycle plus N busy cycles). It releases in the cycle HI/LO already hold the new value, so the MF reads the committed result.
- Back-to-back MDU operations are possible only one cycle after busy falls, because the stall serialises them.
- `hi`/`lo` are registered outputs, stable all cycle.

## Structure
- `md_op` encodings go as `define` constants in the shared macros file, next to the forwarding-select constants.
- State encoding stays local.
- Counter width: $clog2(max(MULT_CYCLES, DIV_CYCLES)+1).
- One sub-module, `md_arith`: purely combinational; takes the op and operands and returns a 64-bit result plus a `div_zero` flag.
- The controller instantiates `md_arith` and holds the FSM, counter, result latch and HI/LO.

## Test plan
- mult with rs=0xFFFFFFFE, rt=3:
  - `busy` high exactly 5 cycles.
  - Then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
  - multu with the same operands gives hi=0x00000002, lo=0xFFFFFFFA.
- div with rs=0xFFFFFFF9 (−7), rt=2: after 10 busy cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- divu with rs=7, rt=2: lo=3, hi=1.
- div, then mflo in D with `md_use_D`=1: `stall_md` is high for 11 consecutive cycles and drops in the cycle `busy` falls with lo already updated.
- Preload hi=0x1234 and lo=0x5678 via mthi/mtlo (each visible the next edge), then div by 0:
  - `busy` high 10 cycles.
  - HI/LO remain 0x1234/0x5678.
- Start mult with 0x10000×0x10000, then:
  - Present mtlo 0xAAAA while busy: ignored.
  - Drop `reset_n` at busy cycle 3: `busy`, `hi`, `lo` go to 0 without waiting for a clock edge.
  - After release, no commit ever occurs (hi stays 0, not 1).
